// File: rtl/universal_shift_register.sv
// Universal DW-bit register: parallel-in/parallel-out, serial-in/parallel-out,
// serial-in/serial-out and parallel-in/serial-out, all sharing one register.
// Serial data enters on inp[DW-1]; serial data leaves on out[0]. Shifting is
// toward the MSB when left_right=0 and toward the LSB when left_right=1.
// Selector codes 4..7 are reserved: the register holds and out reads zero.
module universal_shift_register #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic          l_s,
   input  logic [DW-1:0] inp,
   input  logic          left_right,
   input  logic [2:0]    selector,
   output logic [DW-1:0] out
);

   localparam logic [2:0] SEL_PIPO = 3'd0;
   localparam logic [2:0] SEL_SIPO = 3'd1;
   localparam logic [2:0] SEL_SISO = 3'd2;
   localparam logic [2:0] SEL_PISO = 3'd3;

   logic [DW-1:0] reg_q;
   logic [DW-1:0] reg_d;
   logic          sin;
   logic          sout;
   logic          fill;
   logic [DW-1:0] shifted;

   assign sin = inp[DW-1];

   // Shift the current contents one place in the requested direction.
   // PISO empties with zeros; the serial-input modes fill from sin.
   always_comb begin
      fill    = (selector == SEL_PISO) ? 1'b0 : sin;
      shifted = reg_q;
      if (left_right) begin
         shifted = {fill, reg_q[DW-1:1]};
      end else begin
         shifted = {reg_q[DW-2:0], fill};
      end
   end

   // Next-state select. Disable wins over every mode; reserved codes and
   // l_s outside PISO leave the register untouched.
   always_comb begin
      reg_d = reg_q;
      if (enb) begin
         case (selector)
            SEL_PIPO: reg_d = inp;
            SEL_SIPO: reg_d = shifted;
            SEL_SISO: reg_d = shifted;
            SEL_PISO: reg_d = l_s ? inp : shifted;
            default:  reg_d = reg_q;
         endcase
      end
   end

   // Storage register; reset clears it without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   // Serial output is the bit about to fall off the end in the current direction.
   always_comb begin
      sout = left_right ? reg_q[0] : reg_q[DW-1];
   end

   // Output view depends only on reg_q, selector and left_right, so there is
   // no combinational path from inp to out.
   always_comb begin
      out = '0;
      case (selector)
         SEL_PIPO: out = reg_q;
         SEL_SIPO: out = reg_q;
         SEL_SISO: out = {{(DW-1){1'b0}}, sout};
         SEL_PISO: out = {{(DW-1){1'b0}}, sout};
         default:  out = '0;
      endcase
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (DW=4). Each step drives
// one set of inputs, pushes the expected out for after the next edge onto a
// scoreboard queue, then pops and compares once the edge has happened.
module tb_universal_shift_register;

   localparam int DW = 4;

   logic          clk;
   logic          rst;
   logic          enb;
   logic          l_s;
   logic [DW-1:0] inp;
   logic          left_right;
   logic [2:0]    selector;
   logic [DW-1:0] out;

   int            n_vec;
   int            n_err;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mdl_reg;

   universal_shift_register #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enb        (enb),
      .l_s        (l_s),
      .inp        (inp),
      .left_right (left_right),
      .selector   (selector),
      .out        (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Reference model of the next register value.
   function automatic logic [DW-1:0] mdl_next(input logic [DW-1:0] r, input logic [2:0] sel,
                                              input logic e, input logic ls,
                                              input logic [DW-1:0] d, input logic lr);
      logic f;
      logic [DW-1:0] sh;
      if (!e) return r;
      if (sel > 3'd3) return r;
      if (sel == 3'd0) return d;
      if (sel == 3'd3 && ls) return d;
      f  = (sel == 3'd3) ? 1'b0 : d[DW-1];
      sh = lr ? {f, r[DW-1:1]} : {r[DW-2:0], f};
      return sh;
   endfunction

   function automatic logic [DW-1:0] mdl_out(input logic [DW-1:0] r, input logic [2:0] sel,
                                             input logic lr);
      logic [DW-1:0] o;
      o = '0;
      if (sel == 3'd0 || sel == 3'd1) o = r;
      else if (sel == 3'd2 || sel == 3'd3) o[0] = lr ? r[0] : r[DW-1];
      return o;
   endfunction

   // One clocked step; exp_use selects the explicit expectation over the model.
   task automatic step(input string tag, input logic [2:0] sel, input logic e, input logic ls,
                       input logic [DW-1:0] d, input logic lr,
                       input logic exp_use, input logic [DW-1:0] exp_val);
      logic [DW-1:0] got;
      selector   = sel;
      enb        = e;
      l_s        = ls;
      inp        = d;
      left_right = lr;
      mdl_reg    = mdl_next(mdl_reg, sel, e, ls, d, lr);
      exp_q.push_back(exp_use ? exp_val : mdl_out(mdl_reg, sel, lr));
      @(posedge clk);
      #1;
      got = out;
      chk(tag, got, exp_q.pop_front());
   endtask

   // Reset between edges; out must clear without any clock edge.
   task automatic rst_pulse(input string tag);
      rst = 1'b0;
      #2;
      chk(tag, out, '0);
      rst     = 1'b1;
      mdl_reg = '0;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      mdl_reg    = '0;
      rst        = 1'b0;
      enb        = 1'b0;
      l_s        = 1'b0;
      inp        = '0;
      left_right = 1'b0;
      selector   = 3'd0;
      @(posedge clk);
      #1;
      chk("reset_out", out, 4'b0000);
      rst = 1'b1;

      // PIPO load then hold
      step("pipo_load", 3'd0, 1, 0, 4'd9, 0, 1, 4'b1001);
      step("pipo_hold", 3'd0, 0, 0, 4'd5, 0, 1, 4'b1001);

      // SIPO left
      rst_pulse("rst_sipo_l");
      step("sipo_l0", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0001);
      step("sipo_l1", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0011);
      step("sipo_l2", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0111);
      step("sipo_l3", 3'd1, 1, 0, 4'b0111, 0, 1, 4'b1110);

      // SIPO right
      rst_pulse("rst_sipo_r");
      step("sipo_r0", 3'd1, 1, 0, 4'b1000, 1, 1, 4'b1000);
      step("sipo_r1", 3'd1, 1, 0, 4'b0000, 1, 1, 4'b0100);

      // SISO left: reg 0001,0010,0101,1011
      rst_pulse("rst_siso");
      step("siso_0", 3'd2, 1, 0, 4'b1000, 0, 1, 4'b0000);
      step("siso_1", 3'd2, 1, 0, 4'b0000, 0, 1, 4'b0000);
      step("siso_2", 3'd2, 1, 0, 4'b1000, 0, 1, 4'b0000);
      step("siso_3", 3'd2, 1, 0, 4'b1000, 0, 1, 4'b0001);
      step("siso_view", 3'd0, 0, 0, 4'b0000, 0, 1, 4'b1011);

      // PISO left: load 0011 then empty; no wrap-around
      step("piso_load", 3'd3, 1, 1, 4'd3, 0, 1, 4'b0000);
      step("piso_s0", 3'd3, 1, 0, 4'b1111, 0, 1, 4'b0000);
      step("piso_s1", 3'd3, 1, 0, 4'b1111, 0, 1, 4'b0001);
      step("piso_s2", 3'd3, 1, 0, 4'b1111, 0, 1, 4'b0001);
      step("piso_s3", 3'd3, 1, 0, 4'b1111, 0, 1, 4'b0000);
      step("piso_s4", 3'd3, 1, 0, 4'b1111, 0, 1, 4'b0000);
      step("piso_empty", 3'd0, 0, 0, 4'b1111, 0, 1, 4'b0000);

      // PISO right: load 1010, out[0] follows reg_q[0]
      step("piso_r_load", 3'd3, 1, 1, 4'b1010, 1, 1, 4'b0000);
      step("piso_r_s0", 3'd3, 1, 0, 4'b0000, 1, 1, 4'b0001);
      step("piso_r_view", 3'd0, 0, 0, 4'b0000, 1, 1, 4'b0101);

      // l_s ignored outside PISO
      step("ls_ignored", 3'd0, 1, 1, 4'b0110, 0, 1, 4'b0110);

      // Async reset mid SIPO word, then restart from 0
      rst_pulse("rst_pre");
      step("mid_0", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0001);
      step("mid_1", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0011);
      rst_pulse("rst_mid_word");
      step("mid_restart", 3'd1, 1, 0, 4'b1000, 0, 1, 4'b0001);

      // Reserved selector holds and reads zero
      step("rsv_load", 3'd0, 1, 0, 4'b1010, 0, 1, 4'b1010);
      step("rsv_out", 3'd5, 1, 1, 4'b1111, 0, 1, 4'b0000);
      step("rsv_out7", 3'd7, 1, 0, 4'b0101, 1, 1, 4'b0000);
      step("rsv_kept", 3'd0, 0, 0, 4'b0000, 0, 1, 4'b1010);

      // Random mix checked against the reference model
      for (int i = 0; i < 200; i++) begin
         step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 0, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
